// File: rtl/game_uart_pkg.sv
// rtl/game_uart_pkg.sv - shared event codes, ASCII constants and event entry layout for the game UART paths
package game_uart_pkg;

    typedef enum logic [1:0] {
        EVT_MOVE  = 2'd0,
        EVT_PLACE = 2'd1,
        EVT_WIN   = 2'd2,
        EVT_ERR   = 2'd3
    } evt_code_e;

    // Queued event: {code, x, y}, code in the top two bits
    typedef struct packed {
        evt_code_e  code;
        logic [1:0] x;
        logic [1:0] y;
    } evt_entry_t;

    localparam int ENTRY_W = $bits(evt_entry_t);

    localparam logic [7:0] ASCII_M     = 8'h4D;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_W     = 8'h57;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT = 8'h30;

    // Index of the final byte of a status line (7 bytes, 0..6)
    localparam logic [2:0] MSG_LAST_IDX = 3'd6;

endpackage

// File: rtl/status_fifo.sv
// rtl/status_fifo.sv - synchronous FIFO with full/empty flags and registered occupancy count
module status_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Flags come from the registered count, so a full FIFO refuses a push even if it pops this cycle
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/game_status_tx.sv
// rtl/game_status_tx.sv - buffers game events and serialises each into a 7-byte ASCII status line
module game_status_tx
    import game_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       evt_valid,
    output logic       evt_ready,
    input  logic [1:0] evt_code,
    input  logic [1:0] evt_x,
    input  logic [1:0] evt_y,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    evt_entry_t                msg_q, msg_d;
    logic                      tx_valid_q;
    logic [7:0]                tx_data_q;
    logic                      overflow_q;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [ENTRY_W-1:0]        fifo_wdata;
    logic [ENTRY_W-1:0]        fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Byte idx of the status line for one event; coordinates are not clamped
    function automatic logic [7:0] msg_byte(input evt_entry_t e, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0: begin
                case (e.code)
                    EVT_MOVE:  b = ASCII_M;
                    EVT_PLACE: b = ASCII_P;
                    EVT_WIN:   b = ASCII_W;
                    default:   b = ASCII_E;
                endcase
            end
            3'd1:    b = ASCII_SP;
            3'd2:    b = ASCII_DIGIT + {6'd0, e.x};
            3'd3:    b = ASCII_COMMA;
            3'd4:    b = ASCII_DIGIT + {6'd0, e.y};
            3'd5:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

    assign fifo_wdata = {evt_code, evt_x, evt_y};
    assign fifo_push  = evt_valid && !fifo_full;

    status_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sequencer: load a message from the FIFO, step through its bytes on each handshake, chain messages without a gap
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    msg_d    = evt_entry_t'(fifo_rdata);
                    idx_d    = 3'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q != MSG_LAST_IDX) begin
                        idx_d = idx_q + 3'd1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        msg_d    = evt_entry_t'(fifo_rdata);
                        idx_d    = 3'd0;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                idx_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; the byte outputs are registered from the next state so they stay put during a stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            msg_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            msg_q      <= msg_d;
            tx_valid_q <= (state_d == ST_SEND);
            tx_data_q  <= (state_d == ST_SEND) ? msg_byte(msg_d, idx_d) : 8'h00;
            overflow_q <= overflow_q || (evt_valid && fifo_full);
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign overflow  = overflow_q;
    assign evt_ready = !fifo_full;
    assign busy      = (state_q == ST_SEND) || (fifo_count != '0);

endmodule

// File: tb/tb_game_status_tx.sv
// tb/tb_game_status_tx.sv - directed self-checking bench for game_status_tx
module tb_game_status_tx;

    logic       clk;
    logic       reset;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic [1:0] evt_x;
    logic [1:0] evt_y;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       overflow;

    int n_total  = 0;
    int n_passed = 0;

    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];

    typedef struct {
        logic [1:0]  code;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [55:0] bytes;
    } vec_t;

    vec_t vecs [4];

    game_status_tx #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_x     (evt_x),
        .evt_y     (evt_y),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [1:0] x, input logic [1:0] y);
        evt_valid = 1'b1;
        evt_code  = c;
        evt_x     = x;
        evt_y     = y;
        step();
        evt_valid = 1'b0;
    endtask

    function automatic logic [7:0] model_byte(input logic [1:0] c, input logic [1:0] x,
                                              input logic [1:0] y, input int i);
        case (i)
            0: return (c == 2'd0) ? 8'h4D : (c == 2'd1) ? 8'h50 : (c == 2'd2) ? 8'h57 : 8'h45;
            1: return 8'h20;
            2: return 8'h30 + 8'(x);
            3: return 8'h2C;
            4: return 8'h30 + 8'(y);
            5: return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic model_msg(input logic [1:0] c, input logic [1:0] x, input logic [1:0] y);
        for (int i = 0; i < 7; i++) exp_q.push_back(model_byte(c, x, y, i));
    endtask

    // Receives n bytes; toggle selects ready pattern 1,0,0,1 repeating; checks stall stability
    task automatic collect(input int n, input bit toggle, input int bound, output int cycles);
        logic [3:0] pat;
        logic [7:0] held;
        bit         stalled;
        bit         rdy;
        int         c;
        pat     = 4'b1001;
        held    = 8'h00;
        stalled = 1'b0;
        c       = 0;
        rx_q.delete();
        while (rx_q.size() < n && c < bound) begin
            rdy = toggle ? pat[c % 4] : 1'b1;
            if (stalled) begin
                chk("stall_valid", {31'd0, tx_valid}, 32'd1);
                chk("stall_data", {24'd0, tx_data}, {24'd0, held});
            end
            tx_ready = rdy;
            if (tx_valid && rdy) rx_q.push_back(tx_data);
            stalled = tx_valid && !rdy;
            held    = tx_data;
            step();
            c++;
        end
        cycles = c;
        if (rx_q.size() < n) chk("collect_timeout", rx_q.size(), n);
    endtask

    task automatic cmp_exp(input string name);
        chk({name, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk(name, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int cyc;

        vecs[0] = '{2'd1, 2'd2, 2'd0, 56'h50_20_32_2C_30_0D_0A};
        vecs[1] = '{2'd0, 2'd3, 2'd3, 56'h4D_20_33_2C_33_0D_0A};
        vecs[2] = '{2'd2, 2'd1, 2'd2, 56'h57_20_31_2C_32_0D_0A};
        vecs[3] = '{2'd3, 2'd0, 2'd1, 56'h45_20_30_2C_31_0D_0A};

        reset     = 1'b1;
        evt_valid = 1'b0;
        evt_code  = 2'd0;
        evt_x     = 2'd0;
        evt_y     = 2'd0;
        tx_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("rst_evt_ready", {31'd0, evt_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        // Single events from idle, tx_ready held high
        for (int v = 0; v < 4; v++) begin
            tx_ready = 1'b1;
            push(vecs[v].code, vecs[v].x, vecs[v].y);
            chk("lat_valid_lo", {31'd0, tx_valid}, 32'd0);
            step();
            chk("lat_valid_hi", {31'd0, tx_valid}, 32'd1);
            collect(7, 1'b0, 50, cyc);
            chk("msg_cycles", cyc, 7);
            for (int j = 0; j < 7 && j < rx_q.size(); j++)
                chk("vec_byte", {24'd0, rx_q[j]}, {24'd0, vecs[v].bytes[8*(6-j) +: 8]});
            chk("done_busy", {31'd0, busy}, 32'd0);
            chk("done_tx_valid", {31'd0, tx_valid}, 32'd0);
        end

        // Same place event with ready toggling 1,0,0,1
        push(2'd1, 2'd2, 2'd0);
        step();
        collect(7, 1'b1, 100, cyc);
        exp_q.delete();
        model_msg(2'd1, 2'd2, 2'd0);
        cmp_exp("toggle_byte");
        step();
        chk("toggle_busy", {31'd0, busy}, 32'd0);

        // Three back-to-back events must stream 21 bytes with no idle cycle
        tx_ready = 1'b0;
        push(2'd0, 2'd0, 2'd0);
        push(2'd2, 2'd1, 2'd1);
        push(2'd3, 2'd2, 2'd2);
        collect(21, 1'b0, 100, cyc);
        chk("burst_cycles", cyc, 21);
        exp_q.delete();
        model_msg(2'd0, 2'd0, 2'd0);
        model_msg(2'd2, 2'd1, 2'd1);
        model_msg(2'd3, 2'd2, 2'd2);
        cmp_exp("burst_byte");
        chk("burst_busy", {31'd0, busy}, 32'd0);

        // Overflow: one message stalled in flight, then five pushes into a 4-deep FIFO
        tx_ready = 1'b0;
        push(2'd0, 2'd0, 2'd0);
        step();
        chk("ovf_inflight", {31'd0, tx_valid}, 32'd1);
        push(2'd1, 2'd1, 2'd1);
        chk("ovf_flag_1", {31'd0, overflow}, 32'd0);
        push(2'd2, 2'd2, 2'd2);
        push(2'd3, 2'd3, 2'd3);
        chk("ovf_ready_3", {31'd0, evt_ready}, 32'd1);
        push(2'd0, 2'd1, 2'd2);
        chk("ovf_ready_4", {31'd0, evt_ready}, 32'd0);
        chk("ovf_flag_4", {31'd0, overflow}, 32'd0);
        push(2'd2, 2'd3, 2'd0);
        chk("ovf_flag_5", {31'd0, overflow}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        chk("ovf_hold_data", {24'd0, tx_data}, 32'h4D);
        repeat (3) step();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        collect(35, 1'b0, 100, cyc);
        chk("ovf_cycles", cyc, 35);
        exp_q.delete();
        model_msg(2'd0, 2'd0, 2'd0);
        model_msg(2'd1, 2'd1, 2'd1);
        model_msg(2'd2, 2'd2, 2'd2);
        model_msg(2'd3, 2'd3, 2'd3);
        model_msg(2'd0, 2'd1, 2'd2);
        cmp_exp("ovf_byte");
        repeat (5) step();
        chk("ovf_no_extra", {31'd0, tx_valid}, 32'd0);
        chk("ovf_sticky_end", {31'd0, overflow}, 32'd1);

        // Reset in the middle of a message with another event queued
        tx_ready = 1'b1;
        push(2'd1, 2'd3, 2'd1);
        step();
        chk("mid_valid", {31'd0, tx_valid}, 32'd1);
        push(2'd2, 2'd2, 2'd2);
        step();
        step();
        chk("mid_idx3", {24'd0, tx_data}, 32'h2C);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, tx_valid}, 32'd0);
        step();
        reset = 1'b0;
        chk("rst2_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_evt_ready", {31'd0, evt_ready}, 32'd1);
        chk("rst2_overflow", {31'd0, overflow}, 32'd0);
        repeat (3) step();
        chk("rst2_lost", {31'd0, tx_valid}, 32'd0);
        push(2'd3, 2'd1, 2'd3);
        step();
        collect(7, 1'b0, 50, cyc);
        chk("fresh_cycles", cyc, 7);
        exp_q.delete();
        model_msg(2'd3, 2'd1, 2'd3);
        cmp_exp("fresh_byte");
        chk("fresh_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
